// File: rtl/seq_divider.sv
// Sequential 16/8 unsigned restoring divider: one quotient bit per cycle,
// valid/ready handshake on both sides, early exit on divide-by-zero or overflow.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       err;
  } rsp_t;

  state_t     state;
  rsp_t       rsp_q;
  logic [7:0] r_q;
  logic [7:0] l_q;
  logic [7:0] d_q;
  logic [2:0] cnt;

  logic [8:0] t;
  logic [8:0] diff;
  logic       ge;
  logic [7:0] r_nxt;
  logic [7:0] l_nxt;

  // R < divisor always holds, so T - divisor fits back into 8 bits.
  assign t     = {r_q, l_q[7]};
  assign diff  = t - {1'b0, d_q};
  assign ge    = (t >= {1'b0, d_q});
  assign r_nxt = ge ? diff[7:0] : t[7:0];
  assign l_nxt = {l_q[6:0], ge};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = rsp_q.quo;
  assign remainder = rsp_q.rem;
  assign err       = rsp_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rsp_q <= '0;
      r_q   <= '0;
      l_q   <= '0;
      d_q   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // A high byte >= divisor would need a 9-bit quotient.
            if (divisor == 8'd0 || dividend[15:8] >= divisor) begin
              rsp_q <= '{quo: 8'hFF, rem: 8'h00, err: 1'b1};
              state <= DONE;
            end else begin
              r_q       <= dividend[15:8];
              l_q       <= dividend[7:0];
              d_q       <= divisor;
              cnt       <= 3'd0;
              rsp_q.err <= 1'b0;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          r_q <= r_nxt;
          l_q <= l_nxt;
          if (cnt == 3'd7) begin
            rsp_q <= '{quo: l_nxt, rem: r_nxt, err: 1'b0};
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reference results queued at request time,
// popped and checked when out_valid is observed.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err;

  seq_divider dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
    exp_t m;
    if (dv == 8'd0 || dd[15:8] >= dv) begin
      m = '{q: 8'hFF, r: 8'h00, e: 1'b1};
    end else begin
      m.q = 8'(int'(dd) / int'(dv));
      m.r = 8'(int'(dd) % int'(dv));
      m.e = 1'b0;
    end
    return m;
  endfunction

  // hold > 0 keeps out_ready low for that many cycles in DONE while a
  // conflicting request sits on the input.
  task automatic run(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                     input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    dividend = dd; divisor = dv; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, " accept"}, 32'(in_ready), 32'd1);
    sb.push_back(model(dd, dv));
    if (hold > 0) out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; dividend = 16'hA5A5; divisor = 8'h00;
    chk({tag, " busy"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), e.e ? 32'd1 : 32'd9);
    chk({tag, " quotient"}, 32'(quotient), 32'(e.q));
    chk({tag, " remainder"}, 32'(remainder), 32'(e.r));
    chk({tag, " err"}, 32'(err), 32'(e.e));
    if (!e.e)
      chk({tag, " identity"}, 32'(int'(quotient) * int'(dv) + int'(remainder)), 32'(dd));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = 16'h0100; divisor = 8'd1;
      @(negedge clk);
      chk({tag, " bp valid"}, 32'(out_valid), 32'd1);
      chk({tag, " bp quotient"}, 32'(quotient), 32'(e.q));
      chk({tag, " bp remainder"}, 32'(remainder), 32'(e.r));
      chk({tag, " bp in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " consumed"}, 32'(out_valid), 32'd0);
    chk({tag, " ready again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst quotient", 32'(quotient), 32'd0);
    chk("rst remainder", 32'(remainder), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("3000/100", 16'd3000, 8'd100, 0);
    run("65025/255", 16'd65025, 8'd255, 0);
    run("9437/72", 16'd9437, 8'd72, 0);
    run("1234/0", 16'd1234, 8'd0, 0);
    run("8000h/80h", 16'h8000, 8'h80, 0);
    run("FFFFh/FFh", 16'hFFFF, 8'hFF, 0);
    run("FEFFh/FFh bp", 16'hFEFF, 8'hFF, 5);

    // Abort an operation at its 4th CALC edge.
    @(negedge clk);
    dividend = 16'd5000; divisor = 8'd50; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst remainder", 32'(remainder), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no result", 32'(seen), 32'd0);
    run("100/7", 16'd100, 8'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter-free fixed widths: 16-bit dividend, 8-bit divisor, 8-bit quotient, 8-bit remainder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request valid; dividend and divisor stable while high.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 dividend  input  16  unsigned dividend.
REQ-007 divisor  input  8  unsigned divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  8  unsigned quotient.
REQ-011 remainder  output  8  unsigned remainder.
REQ-012 err  output  1  divide-by-zero or quotient overflow; qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept SHALL occur on an edge with in_valid & in_ready; operands are captured into internal registers and inputs are ignored afterwards.
REQ-015 On accept, when divisor==0 or dividend[15:8] >= divisor, the FSM SHALL go directly to DONE with err=1, quotient=8'hFF, remainder=8'h00 (latency 1 edge).
REQ-016 Otherwise the FSM SHALL go to CALC with partial remainder R=dividend[15:8], shift register L=dividend[7:0], iteration counter=0, err=0.
REQ-017 Each CALC edge SHALL form T={R,L[7]} (9 bits); if T >= divisor then R=T-divisor and the quotient bit=1, else R=T[7:0] and the quotient bit=0; L shifts left by one with the quotient bit entering at L[0].
REQ-018 CALC SHALL last exactly 8 edges, producing quotient bits MSB first. On the 8th edge the FSM SHALL move to DONE with quotient=L and remainder=R.
REQ-019 Non-error latency SHALL be 9 edges from the accept edge to out_valid observed high.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, whenever err=0.
REQ-021 In DONE, quotient, remainder and err SHALL hold stable until the edge with out_valid & out_ready; that edge SHALL return the FSM to IDLE.
REQ-022 A new request SHALL NOT be accepted on the same edge a result is consumed; the earliest next accept is the following edge.
REQ-023 in_valid asserted during CALC or DONE SHALL have no effect; the request is held by the producer until in_ready is high.
REQ-024 out_ready asserted outside DONE SHALL be ignored.
REQ-025 The iteration counter SHALL be 3 bits and SHALL NOT wrap during an operation; CALC exits on count 7.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, err=0, and clear the counter and internal registers.
REQ-027 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-028 Reset deassertion SHALL be synchronised by the integrator; the first accept is legal on the first edge after rst_n goes high.

Verification
REQ-029 dividend=3000, divisor=100 -> after 9 edges out_valid=1, quotient=30, remainder=0, err=0.
REQ-030 Back-to-back requests 65025/255 then 9437/72, with out_ready held high -> 255 r0, then 131 r5; in_ready is high one edge after each consume.
REQ-031 divisor=0 (dividend=1234), and separately 16'h8000/8'h80 -> out_valid after 1 edge, err=1, quotient=8'hFF, remainder=0.
REQ-032 dividend=16'hFFFF, divisor=8'hFF is an overflow (err=1); dividend=16'hFEFF, divisor=8'hFF -> 255 r254, err=0.
REQ-033 Backpressure: out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; the result is consumed on the first out_ready-high edge.
REQ-034 rst_n pulsed low at the 4th CALC edge -> outputs immediately zero with in_ready=1; a following 100/7 request returns 14 r2.
